// File: rtl/loader_pkg.sv
// Shared state encoding and stream/word geometry for the instruction-memory boot loader.
package loader_pkg;

  typedef enum logic [2:0] {
    LEN0,
    LEN1,
    DATA,
    CHECK,
    RUN,
    ERROR
  } loader_state_t;

  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_W          = 8 * LEN_BYTES;
  localparam int WORD_W         = 8 * BYTES_PER_WORD;

endpackage

// File: rtl/byte_assembler.sv
// Packs a little-endian byte stream into 32-bit words; word_ready pulses the
// cycle after the fourth byte, while word still holds the completed value.
module byte_assembler
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              strobe,
  input  logic              clear,
  input  logic [7:0]        data,
  output logic [1:0]        byte_cnt,
  output logic [WORD_W-1:0] word,
  output logic              word_ready
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt   <= '0;
      word       <= '0;
      word_ready <= 1'b0;
    end else begin
      word_ready <= 1'b0;
      if (clear) begin
        byte_cnt <= '0;
        word     <= '0;
      end else if (strobe) begin
        // Shifting in at the top leaves byte k at bits [8k+7:8k] after four bytes.
        word       <= {data, word[WORD_W-1:8]};
        byte_cnt   <= byte_cnt + 2'd1;
        word_ready <= (byte_cnt == 2'(BYTES_PER_WORD - 1));
      end
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot sequencer: holds the core in reset, loads a UART program image into
// instruction memory, then releases the core. LOADER_CHECKSUM_EN adds a trailing XOR byte.
module imem_boot_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W         = 10,
  parameter int TIMEOUT_CYCLES = 100000
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              load_req,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              load_done,
  output logic              error
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [LEN_W:0] CAPACITY = {{LEN_W{1'b0}}, 1'b1} << ADDR_W;

  loader_state_t     state, state_nxt;
  logic [7:0]        len_lo;
  logic [LEN_W-1:0]  n_words, len_full;
  logic [ADDR_W-1:0] word_idx;
  logic [IDLE_W-1:0] idle_cnt;
  logic              timed, timeout, go_load;
  logic              asm_strobe, asm_clear, last_byte, last_word;
  logic [1:0]        byte_cnt;
  logic [WORD_W-1:0] word;
  logic              word_ready;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`else
  logic              data_done;
`endif

  assign len_full  = {rx_data, len_lo};
  assign timed     = (state == LEN1) || (state == DATA) || (state == CHECK);
  assign timeout   = timed && !rx_valid && (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));
  assign go_load   = load_req && ((state == RUN) || (state == ERROR));
  assign last_word = (word_idx == ADDR_W'(n_words - 1'b1));
`ifdef LOADER_CHECKSUM_EN
  assign asm_strobe = rx_valid && (state == DATA);
`else
  // Once the final byte is in, stray bytes must not start a new word.
  assign asm_strobe = rx_valid && (state == DATA) && !data_done;
`endif
  assign last_byte = asm_strobe && (byte_cnt == 2'(BYTES_PER_WORD - 1));
  assign asm_clear = go_load || timeout;

  byte_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .strobe     (asm_strobe),
    .clear      (asm_clear),
    .data       (rx_data),
    .byte_cnt   (byte_cnt),
    .word       (word),
    .word_ready (word_ready)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      LEN0: if (rx_valid) state_nxt = LEN1;
      LEN1: begin
        if (rx_valid) begin
          if ({1'b0, len_full} > CAPACITY) state_nxt = ERROR;
          else if (len_full == '0) begin
`ifdef LOADER_CHECKSUM_EN
            state_nxt = CHECK;
`else
            state_nxt = RUN;
`endif
          end else state_nxt = DATA;
        end else if (timeout) state_nxt = ERROR;
      end
      DATA: begin
`ifdef LOADER_CHECKSUM_EN
        if (last_byte && last_word) state_nxt = CHECK;
        else if (timeout)           state_nxt = ERROR;
`else
        // Leave one cycle after the final byte so the last write lands before release.
        if (data_done)    state_nxt = RUN;
        else if (timeout) state_nxt = ERROR;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        if (rx_valid)     state_nxt = (rx_data == csum) ? RUN : ERROR;
        else if (timeout) state_nxt = ERROR;
      end
`endif
      RUN:     if (load_req) state_nxt = LEN0;
      ERROR:   if (load_req) state_nxt = LEN0;
      default: state_nxt = LEN0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LEN0;
      len_lo    <= '0;
      n_words   <= '0;
      word_idx  <= '0;
      idle_cnt  <= '0;
      load_done <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum      <= '0;
`else
      data_done <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      load_done <= (state_nxt == RUN) && (state != RUN);
      if (state == LEN0 && rx_valid) len_lo  <= rx_data;
      if (state == LEN1 && rx_valid) n_words <= len_full;
      if (go_load)         word_idx <= '0;
      else if (word_ready) word_idx <= word_idx + 1'b1;
      if (!timed || rx_valid) idle_cnt <= '0;
      else                    idle_cnt <= idle_cnt + 1'b1;
`ifdef LOADER_CHECKSUM_EN
      if (state == LEN1)   csum <= '0;
      else if (asm_strobe) csum <= csum ^ rx_data;
`else
      if (state != DATA)                data_done <= 1'b0;
      else if (last_byte && last_word)  data_done <= 1'b1;
`endif
    end
  end

  assign imem_we    = word_ready;
  assign imem_addr  = word_idx;
  assign imem_wdata = word;
  assign core_rst   = (state != RUN);
  assign error      = (state == ERROR);

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: table of byte streams plus hand-written
// sequences for reload, timeout boundary, maximum image size and mid-load reset.
module tb_imem_boot_loader;

  localparam int ADDR_W = 10;
  localparam int TO     = 20;
  localparam int AW     = ADDR_W + 32;

  logic              clk = 1'b0;
  logic              rst, rx_valid, load_req;
  logic [7:0]        rx_data;
  logic              imem_we, core_rst, load_done, error;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  imem_boot_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .load_req   (load_req),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst   (core_rst),
    .load_done  (load_done),
    .error      (error)
  );

  always #5 clk = ~clk;

  // clock/cycle bookkeeping and output monitor
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [AW-1:0] got_q[$];
  logic [AW-1:0] exp_q[$];
  int   done_cnt = 0, last_we_cyc = 0, fall_cyc = 0, done_cyc = 0;
  logic prev_core_rst = 1'b1;

  always @(negedge clk) begin
    if (imem_we) begin
      got_q.push_back({imem_addr, imem_wdata});
      last_we_cyc = cyc;
    end
    if (load_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (prev_core_rst && !core_rst) fall_cyc = cyc;
    prev_core_rst = core_rst;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_writes(input string name);
    chk({name, " nwrites"}, 64'(got_q.size()), 64'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0)
      chk({name, " write"}, 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
    got_q.delete();
    exp_q.delete();
  endtask

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_req();
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  typedef struct packed {
    logic                   req;
    int                     nb;
    logic [95:0]            b;
    int                     nw;
    logic [1:0][ADDR_W-1:0] wa;
    logic [1:0][31:0]       wd;
    logic                   e_err;
    logic                   e_crst;
    int                     e_done;
  } vec_t;

  vec_t vecs[$];
  vec_t v;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = '0; load_req = 1'b0;

    // basic two-word load
    v = '0; v.req = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    v.nb = 11; v.b = 96'h02001305100093052000B000;
`else
    v.nb = 10; v.b = 96'h020013051000930520000000;
`endif
    v.nw = 2; v.wa[0] = 0; v.wd[0] = 32'h00100513; v.wa[1] = 1; v.wd[1] = 32'h00200593;
    v.e_err = 1'b0; v.e_crst = 1'b0; v.e_done = 1;
    vecs.push_back(v);
    // oversize count 1025
    v = '0; v.req = 1'b1; v.nb = 2; v.b = 96'h010400000000000000000000;
    v.e_err = 1'b1; v.e_crst = 1'b1; v.e_done = 0;
    vecs.push_back(v);
    // zero-length image
    v = '0; v.req = 1'b1;
`ifdef LOADER_CHECKSUM_EN
    v.nb = 3;
`else
    v.nb = 2;
`endif
    v.b = 96'h0; v.e_err = 1'b0; v.e_crst = 1'b0; v.e_done = 1;
    vecs.push_back(v);
    // single word 0x44332211
    v = '0; v.req = 1'b1;
`ifdef LOADER_CHECKSUM_EN
    v.nb = 7; v.b = 96'h010011223344440000000000;
`else
    v.nb = 6; v.b = 96'h010011223344000000000000;
`endif
    v.nw = 1; v.wa[0] = 0; v.wd[0] = 32'h44332211;
    v.e_err = 1'b0; v.e_crst = 1'b0; v.e_done = 1;
    vecs.push_back(v);
`ifdef LOADER_CHECKSUM_EN
    // bad checksum: word still written, core held
    v = '0; v.req = 1'b1; v.nb = 7; v.b = 96'h010011223344450000000000;
    v.nw = 1; v.wa[0] = 0; v.wd[0] = 32'h44332211;
    v.e_err = 1'b1; v.e_crst = 1'b1; v.e_done = 0;
    vecs.push_back(v);
`endif

    settle(3);
    chk("reset core_rst", 64'(core_rst), 64'd1);
    chk("reset imem_we", 64'(imem_we), 64'd0);
    chk("reset imem_addr", 64'(imem_addr), 64'd0);
    chk("reset imem_wdata", 64'(imem_wdata), 64'd0);
    chk("reset load_done", 64'(load_done), 64'd0);
    chk("reset error", 64'(error), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    settle(2);
    chk("idle core_rst", 64'(core_rst), 64'd1);

    foreach (vecs[i]) begin
      v = vecs[i];
      if (v.req) pulse_req();
      done_cnt = 0;
      for (int k = 0; k < v.nw; k++) exp_q.push_back({v.wa[k], v.wd[k]});
      for (int k = 0; k < v.nb; k++) send_byte(v.b[95 - 8*k -: 8]);
      settle(4);
      chk($sformatf("vec%0d error", i), 64'(error), 64'(v.e_err));
      chk($sformatf("vec%0d core_rst", i), 64'(core_rst), 64'(v.e_crst));
      chk($sformatf("vec%0d load_done", i), 64'(done_cnt), 64'(v.e_done));
      if (v.e_done == 1 && v.nw > 0) begin
        chk($sformatf("vec%0d release after write", i), 64'(fall_cyc > last_we_cyc), 64'd1);
        chk($sformatf("vec%0d done with release", i), 64'(done_cyc), 64'(fall_cyc));
      end
      check_writes($sformatf("vec%0d", i));
    end

    // reload mid-run with a simultaneous byte that must be dropped
    pulse_req();
    send_byte(8'h00); send_byte(8'h00);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    settle(3);
    chk("pre-reload core_rst", 64'(core_rst), 64'd0);
    @(negedge clk);
    load_req = 1'b1; rx_valid = 1'b1; rx_data = 8'h03;
    @(negedge clk);
    load_req = 1'b0; rx_valid = 1'b0;
    chk("reload core_rst", 64'(core_rst), 64'd1);
    exp_q.push_back({10'd0, 32'hEFBEADDE});
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h22);
`endif
    settle(4);
    chk("reload released", 64'(core_rst), 64'd0);
    check_writes("reload");

    // timeout after a partial word: TO-1 silent cycles keep it alive, TO expires
    pulse_req();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'hAA); send_byte(8'hBB);
    repeat (TO - 1) @(negedge clk);
    #1;
    chk("timeout not yet", 64'(error), 64'd0);
    @(negedge clk);
    #1;
    chk("timeout error", 64'(error), 64'd1);
    chk("timeout core_rst", 64'(core_rst), 64'd1);
    settle(3);
    check_writes("timeout");

    // byte arriving on the expiry cycle keeps the load alive
    pulse_req();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'hAA); send_byte(8'hBB);
    repeat (TO - 2) @(negedge clk);
    send_byte(8'hCC);
    #1;
    chk("expiry byte wins", 64'(error), 64'd0);
    exp_q.push_back({10'd0, 32'hDDCCBBAA});
    send_byte(8'hDD);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    settle(4);
    chk("expiry load error", 64'(error), 64'd0);
    chk("expiry load core_rst", 64'(core_rst), 64'd0);
    check_writes("expiry");

    // largest legal image (1024 words) is accepted, then times out idle in DATA
    pulse_req();
    send_byte(8'h00); send_byte(8'h04);
    settle(2);
    chk("max count accepted", 64'(error), 64'd0);
    chk("max count core_rst", 64'(core_rst), 64'd1);
    settle(TO + 2);
    chk("max count timeout", 64'(error), 64'd1);

    // asynchronous reset in the middle of a load
    pulse_req();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h55); send_byte(8'h66);
    #2;
    rst = 1'b1;
    #1;
    chk("mid rst core_rst", 64'(core_rst), 64'd1);
    chk("mid rst error", 64'(error), 64'd0);
    chk("mid rst imem_wdata", 64'(imem_wdata), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back({10'd0, 32'h04030201});
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h04);
`endif
    settle(4);
    chk("post rst load", 64'(core_rst), 64'd0);
    check_writes("post rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
